seq_int_to_fp_converter: RTL and testbench

SEQ_INT_TO_FP_CONVERTER -- requirements
Module: seq_int_to_fp_converter

---
 rtl/float_types_pkg.sv | 31 +++
 rtl/fp_round_rne.sv | 42 ++++
 rtl/seq_int_to_fp_converter.sv | 112 +++++++++++
 tb/tb_seq_int_to_fp_converter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/float_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float_types_pkg
// Description : Shared floating-point types and constants for the integer to
//               IEEE-754 single-precision converter.
//               - float_point_num : packed sign / 8-bit exponent / 23-bit frac
//               - fp_status_e     : result status codes
//               - c_BIAS          : single-precision exponent bias
//               - c_EXP_BASE      : exponent of a magnitude whose MSB sits at
//                                   bit 31 (bias + 31)
// Revision    : 1.0 - initial release
// ============================================================================
package float_types_pkg;

   typedef struct packed {
      logic       sign;
      logic [7:0] exp;
      logic [22:0] frac;
   } float_point_num;

   typedef enum logic [1:0] {
      OK_state   = 2'd0,
      ZERO_res   = 2'd1,
      NAN_or_INF = 2'd2
   } fp_status_e;

   localparam logic [7:0] c_BIAS     = 8'd127;
   localparam logic [7:0] c_EXP_BASE = c_BIAS + 8'd31;

endpackage : float_types_pkg
`default_nettype wire

// File: rtl/fp_round_rne.sv
`default_nettype none
// ============================================================================
// Module      : fp_round_rne
// Description : Combinational round-to-nearest-even of a normalized 32-bit
//               magnitude (bit 31 set) into a 23-bit stored fraction.
// Ports       : i_mag  [31:0] normalized magnitude
//               i_exp  [7:0]  exponent before rounding
//               o_frac [22:0] rounded stored fraction
//               o_exp  [7:0]  exponent after rounding carry
// Revision    : 1.0 - initial release
// ============================================================================
module fp_round_rne (
   input  logic [31:0] i_mag,
   input  logic [7:0]  i_exp,
   output logic [22:0] o_frac,
   output logic [7:0]  o_exp
);

   logic [22:0] w_frac;
   logic        w_guard;
   logic        w_sticky;
   logic        w_round_up;
   logic [23:0] w_sum;
   // The hidden one is implied by normalization and carries no information.
   logic        w_unused_hidden;

   assign w_unused_hidden = i_mag[31];
   assign w_frac          = i_mag[30:8];
   assign w_guard         = i_mag[7];
   assign w_sticky        = |i_mag[6:0];

   // Exact ties (guard set, nothing below) round toward an even fraction.
   assign w_round_up = w_guard & (w_sticky | w_frac[0]);
   assign w_sum      = {1'b0, w_frac} + {23'd0, w_round_up};

   // A carry out of the fraction leaves the low 23 bits at zero, so only
   // the exponent needs adjusting.
   assign o_frac = w_sum[22:0];
   assign o_exp  = i_exp + {7'd0, w_sum[23]};

endmodule : fp_round_rne
`default_nettype wire

// File: rtl/seq_int_to_fp_converter.sv
`default_nettype none
// ============================================================================
// Module      : seq_int_to_fp_converter
// Description : Sequential converter from a 32-bit signed integer to an
//               IEEE-754 single-precision value. Normalizes one bit per
//               cycle, then rounds to nearest even.
// Ports       : clk_i           clock
//               rst_i           synchronous active-high reset
//               vld_i / int_i   operand handshake and signed operand
//               rdy_o           high while idle (operand accepted)
//               vld_o / rdy_i   result handshake
//               answer_o        packed single-precision result
//               answer_status_o OK_state / ZERO_res / NAN_or_INF
// Revision    : 1.0 - initial release
// ============================================================================
module seq_int_to_fp_converter
   import float_types_pkg::*;
(
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           vld_i,
   input  logic [31:0]    int_i,
   output logic           rdy_o,
   output logic           vld_o,
   input  logic           rdy_i,
   output float_point_num answer_o,
   output logic [1:0]     answer_status_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e      r_state;
   logic        r_sign;
   logic [31:0] r_mag;
   logic [4:0]  r_k;

   logic [31:0] w_abs;
   logic [7:0]  w_exp_in;
   logic [22:0] w_rnd_frac;
   logic [7:0]  w_rnd_exp;

   // -2^31 negates to itself, which read as unsigned is the correct magnitude.
   assign w_abs    = int_i[31] ? (~int_i + 32'd1) : int_i;
   assign w_exp_in = c_EXP_BASE - {3'd0, r_k};

   assign rdy_o = (r_state == IDLE);
   assign vld_o = (r_state == DONE);

   fp_round_rne u_round (
      .i_mag  (r_mag),
      .i_exp  (w_exp_in),
      .o_frac (w_rnd_frac),
      .o_exp  (w_rnd_exp)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state         <= IDLE;
         r_sign          <= 1'b0;
         r_mag           <= 32'd0;
         r_k             <= 5'd0;
         answer_o        <= '0;
         answer_status_o <= OK_state;
      end else begin
         case (r_state)
            IDLE: begin
               if (vld_i) begin
                  r_sign <= int_i[31];
                  r_mag  <= w_abs;
                  r_k    <= 5'd0;
                  if (int_i == 32'd0) begin
                     answer_o        <= '0;
                     answer_status_o <= ZERO_res;
                     r_state         <= DONE;
                  end else begin
                     r_state <= NORM;
                  end
               end
            end
            NORM: begin
               if (r_mag[31]) begin
                  r_state <= ROUND;
               end else begin
                  r_mag <= r_mag << 1;
                  r_k   <= r_k + 5'd1;
               end
            end
            ROUND: begin
               // Exponent tops out at 158, so overflow to Inf cannot occur.
               answer_o.sign   <= r_sign;
               answer_o.exp    <= w_rnd_exp;
               answer_o.frac   <= w_rnd_frac;
               answer_status_o <= OK_state;
               r_state         <= DONE;
            end
            DONE: begin
               if (rdy_i) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule : seq_int_to_fp_converter
`default_nettype wire

// File: tb/tb_seq_int_to_fp_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_int_to_fp_converter
// Description : Self-checking bench for seq_int_to_fp_converter. Expected
//               results come from an arithmetic model of integer-to-single
//               conversion with round-to-nearest-even.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_int_to_fp_converter;
   import float_types_pkg::*;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           vld_in = 1'b0;
   logic [31:0]    int_in = 32'd0;
   logic           rdy_out;
   logic           vld_out;
   logic           rdy_in = 1'b0;
   float_point_num answer;
   logic [1:0]     status;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] last_answer;

   always #5 clk = ~clk;

   seq_int_to_fp_converter dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .vld_i           (vld_in),
      .int_i           (int_in),
      .rdy_o           (rdy_out),
      .vld_o           (vld_out),
      .rdy_i           (rdy_in),
      .answer_o        (answer),
      .answer_status_o (status)
   );

   task automatic check_value(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Position of the most significant set bit of |v| (v nonzero).
   function automatic int ref_msb(input logic [31:0] v);
      logic [63:0] mag;
      int p;
      mag = {32'd0, v};
      if (v[31]) mag = 64'h1_0000_0000 - mag;
      p = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) p = i;
      return p;
   endfunction

   function automatic logic [31:0] ref_fp(input logic [31:0] v);
      logic [63:0] mag, q, rem, half;
      int p, sh;
      logic [7:0] e;
      if (v == 32'd0) return 32'd0;
      mag = {32'd0, v};
      if (v[31]) mag = 64'h1_0000_0000 - mag;
      p = ref_msb(v);
      if (p <= 23) begin
         q = mag << (23 - p);
      end else begin
         sh   = p - 23;
         q    = mag >> sh;
         rem  = mag - (q << sh);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      end
      e = 8'(127 + p);
      if (q == (64'd1 << 24)) begin
         e = e + 8'd1;
         q = q >> 1;
      end
      return {v[31], e, q[22:0]};
   endfunction

   task automatic wait_ready();
      int guard;
      guard = 0;
      while (!rdy_out && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!rdy_out) check_value("rdy_wait", {31'd0, rdy_out}, 32'd1);
   endtask

   task automatic convert(input logic [31:0] v, input int stall);
      int cyc, exp_lat;
      logic [31:0] held;
      exp_lat = (v == 32'd0) ? 1 : 34 - ref_msb(v);
      wait_ready();
      vld_in = 1'b1;
      int_in = v;
      @(posedge clk); #1;
      vld_in = 1'b0;
      int_in = $urandom;
      cyc = 1;
      while (!vld_out && cyc < 40) begin
         vld_in = 1'($urandom_range(0, 1));
         int_in = $urandom;
         @(posedge clk); #1;
         cyc++;
      end
      check_value("latency", cyc, exp_lat);
      check_value("answer", answer, ref_fp(v));
      check_value("status", {30'd0, status},
                  {30'd0, (v == 32'd0) ? ZERO_res : OK_state});
      held = answer;
      repeat (stall) begin
         vld_in = 1'($urandom_range(0, 1));
         int_in = $urandom;
         @(posedge clk); #1;
         check_value("hold_answer", answer, held);
         check_value("hold_vld", {31'd0, vld_out}, 32'd1);
         check_value("hold_rdy", {31'd0, rdy_out}, 32'd0);
      end
      vld_in = 1'b0;
      rdy_in = 1'b1;
      @(posedge clk); #1;
      rdy_in = 1'b0;
      check_value("idle_rdy", {31'd0, rdy_out}, 32'd1);
      check_value("idle_vld", {31'd0, vld_out}, 32'd0);
      check_value("idle_hold", answer, held);
      last_answer = answer;
   endtask

   logic [31:0] dir_in  [7] = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'd16777217,
                                32'd16777219, 32'h7FFF_FFFF, 32'h8000_0000};
   logic [31:0] dir_exp [7] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000,
                                32'h4B80_0000, 32'h4B80_0002, 32'h4F00_0000,
                                32'hCF00_0000};

   initial begin
      logic [31:0] v;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_value("rst_rdy", {31'd0, rdy_out}, 32'd1);
      check_value("rst_vld", {31'd0, vld_out}, 32'd0);
      check_value("rst_answer", answer, 32'd0);
      check_value("rst_status", {30'd0, status}, {30'd0, OK_state});

      for (int i = 0; i < 7; i++) begin
         convert(dir_in[i], 0);
         check_value("directed", last_answer, dir_exp[i]);
      end

      // Result held in DONE while downstream stalls, vld_i pulses ignored.
      convert(32'd12345, 5);

      // Reset in the middle of normalization.
      wait_ready();
      vld_in = 1'b1;
      int_in = 32'd1;
      @(posedge clk); #1;
      vld_in = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_value("abort_vld", {31'd0, vld_out}, 32'd0);
      check_value("abort_answer", answer, 32'd0);
      check_value("abort_rdy", {31'd0, rdy_out}, 32'd1);
      convert(32'd3, 0);
      check_value("after_abort", last_answer, 32'h4040_0000);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = $urandom >> $urandom_range(0, 31);
            2: v = -($urandom >> $urandom_range(0, 31));
            default: v = 32'($urandom_range(0, 300)) - 32'd150;
         endcase
         convert(v, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_seq_int_to_fp_converter
`default_nettype wire
